// File: rtl/ext_pipe_unit.sv
// Pipelined immediate extender for the decode stage. It covers zero/sign/upper/branch-offset
// modes, has stall and flush control, and provides a sticky illegal-mode flag and a delivery counter.
module ext_pipe_unit #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int LAT    = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        op_ext,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] ext_out,
    output logic              out_valid,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  out_count
);

    generate
        if (DATA_W < IMM_W + 2 || LAT < 1 || LAT > 4) begin : g_param_check
            $error("ext_pipe_unit: requires DATA_W >= IMM_W + 2 and 1 <= LAT <= 4");
        end
    endgenerate

    logic              w_accept;
    logic              w_illegal;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_ext;

    assign w_accept  = in_valid & ~stall & ~flush;
    assign w_illegal = op_ext[2] & (op_ext[1:0] != 2'b00);
    assign w_sext    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_zext    = {{(DATA_W-IMM_W){1'b0}}, imm};

    // Stage-0 computation; the pipeline registers below only carry the result forward.
    always_comb begin
        w_ext = '0;
        case (op_ext)
            3'b000:  w_ext = w_zext;
            3'b001:  w_ext = w_sext;
            3'b010:  w_ext = {imm, {(DATA_W-IMM_W){1'b0}}};
            3'b011:  w_ext = {w_sext[DATA_W-3:0], 2'b00};
            3'b100:  w_ext = {w_zext[DATA_W-3:0], 2'b00};
            default: w_ext = '0;
        endcase
    end

    logic [LAT-1:0]    r_vld;
    logic [DATA_W-1:0] r_data [LAT];
    logic [LAT-1:0]    w_vld_in;
    logic [DATA_W-1:0] w_data_in [LAT];

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_vld_in[gi]  = w_accept;
                assign w_data_in[gi] = w_ext;
            end else begin : g_link
                assign w_vld_in[gi]  = r_vld[gi-1];
                assign w_data_in[gi] = r_data[gi-1];
            end
        end
    endgenerate

    // Flush wins over stall; reset wins over both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else if (!stall) begin
            r_vld <= w_vld_in;
        end
    end

    // Data needs no reset: the output is masked by the valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = 0; i < LAT; i++) begin
                r_data[i] <= w_data_in[i];
            end
        end
    end

    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end
            if (r_vld[LAT-1] && !stall && !flush) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid  = r_vld[LAT-1];
    assign ext_out    = r_vld[LAT-1] ? r_data[LAT-1] : '0;
    assign err_sticky = r_err;
    assign out_count  = r_cnt;

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Self-checking bench for ext_pipe_unit. It runs four instances (LAT 1/3/2/4, one with CNT_W=2)
// in parallel against a reference model. The model keeps a history of pipeline advances.
module tb_ext_pipe_unit;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [15:0] imm;
    logic [2:0]  op_ext;

    logic [31:0] ext_o [4];
    logic        ov    [4];
    logic        er    [4];
    logic [7:0]  cnt_o [4];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            localparam int L  = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 2 : 4;
            localparam int CW = (gi == 2) ? 2 : 8;
            logic [CW-1:0] c;
            logic [31:0]   e;
            logic          v, r;
            ext_pipe_unit #(.IMM_W(16), .DATA_W(32), .LAT(L), .CNT_W(CW)) u_dut (
                .clk(clk), .reset(reset), .imm(imm), .op_ext(op_ext),
                .in_valid(in_valid), .stall(stall), .flush(flush),
                .ext_out(e), .out_valid(v), .err_sticky(r), .out_count(c)
            );
            assign ext_o[gi] = e;
            assign ov[gi]    = v;
            assign er[gi]    = r;
            assign cnt_o[gi] = 8'(c);
        end
    endgenerate

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: hv/hd[n] hold what entered stage 0 at the n-th advancing edge.
    // An entry reaches the output LAT-1 advances later, unless a flush/reset came after it.
    bit          hv [8192];
    logic [31:0] hd [8192];
    int          adv = 0;
    int          kill_lim = 0;
    bit          m_err = 0;
    int          m_cnt [4] = '{0, 0, 0, 0};

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_ext(input logic [15:0] im, input logic [2:0] op);
        int          s = int'($signed(im));
        int unsigned z = 32'(im);
        case (op)
            3'd0:    return z;
            3'd1:    return s;
            3'd2:    return z * 65536;
            3'd3:    return s * 4;
            3'd4:    return z * 4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_ov(input int k);
        int idx = adv - lat_of(k) + 1;
        return (idx > kill_lim) && hv[idx];
    endfunction

    function automatic logic [31:0] m_ext(input int k);
        int idx = adv - lat_of(k) + 1;
        return m_ov(k) ? hd[idx] : 32'd0;
    endfunction

    task automatic model_step();
        if (reset) begin
            kill_lim = adv;
            m_err    = 0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (m_ov(k) && !stall && !flush) m_cnt[k] = (m_cnt[k] + 1) % ((k == 2) ? 4 : 256);
            if (in_valid && !stall && !flush && op_ext >= 3'd5) m_err = 1;
            if (!stall) begin
                adv++;
                hv[adv] = in_valid && !flush;
                hd[adv] = ref_ext(imm, op_ext);
            end
            if (flush) kill_lim = adv;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("u%0d.out_valid", k), 32'(ov[k]), 32'(m_ov(k)));
            check_eq($sformatf("u%0d.ext_out", k), ext_o[k], m_ext(k));
            check_eq($sformatf("u%0d.out_count", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
            check_eq($sformatf("u%0d.err_sticky", k), 32'(er[k]), 32'(m_err));
        end
    endtask

    task automatic cyc(input bit rs, input bit iv, input bit st, input bit fl,
                       input logic [2:0] op, input logic [15:0] im);
        reset = rs; in_valid = iv; stall = st; flush = fl; op_ext = op; imm = im;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        $display("cyc rst=%0b v=%0b st=%0b fl=%0b op=%0d imm=%h | u0 %0b:%h u1 %0b:%h cnt1=%0d err=%0b",
                 rs, iv, st, fl, op, im, ov[0], ext_o[0], ov[1], ext_o[1], cnt_o[1], er[0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 3'd0, 16'h0);
    endtask

    logic [31:0] seen [$];
    logic [2:0]  sweep_op  [5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [31:0] sweep_exp [5] = '{32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFC, 32'h0003FFFC, 32'h0};
    logic [7:0]  c_before;

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 3'd0, 16'h0);
        cyc(1, 0, 0, 0, 3'd0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            check_eq("reset.out_valid", 32'(ov[k]), 32'd0);
            check_eq("reset.ext_out", ext_o[k], 32'd0);
        end

        // LAT=1 sign extension, then delivery count
        cyc(0, 1, 0, 0, 3'd1, 16'h8001);
        check_eq("sext.ext_out", ext_o[0], 32'hFFFF8001);
        check_eq("sext.out_valid", 32'(ov[0]), 32'd1);
        idle(1);
        check_eq("sext.out_count", 32'(cnt_o[0]), 32'd1);

        // Mode sweep with imm FFFF
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, sweep_op[i], 16'hFFFF);
            check_eq($sformatf("sweep.op%0d", sweep_op[i]), ext_o[0], sweep_exp[i]);
        end
        check_eq("sweep.err_set", 32'(er[0]), 32'd1);
        cyc(0, 1, 0, 0, 3'd1, 16'h1234);
        idle(5);
        check_eq("sweep.err_held", 32'(er[0]), 32'd1);

        // LAT=3 stream 1,2,3 with a stall in the second cycle
        c_before = cnt_o[1];
        seen.delete();
        cyc(0, 1, 0, 0, 3'd0, 16'd1);
        if (ov[1]) seen.push_back(ext_o[1]);
        cyc(0, 1, 1, 0, 3'd0, 16'd2);
        if (ov[1]) seen.push_back(ext_o[1]);
        cyc(0, 1, 0, 0, 3'd0, 16'd2);
        if (ov[1]) seen.push_back(ext_o[1]);
        cyc(0, 1, 0, 0, 3'd0, 16'd3);
        if (ov[1]) seen.push_back(ext_o[1]);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (ov[1]) seen.push_back(ext_o[1]);
        end
        check_eq("stall.count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < seen.size() && i < 3; i++)
            check_eq($sformatf("stall.order%0d", i), seen[i], 32'(i + 1));
        check_eq("stall.out_count", 32'(cnt_o[1] - c_before), 32'd3);

        // Flush together with stall, two entries in flight
        cyc(0, 1, 0, 0, 3'd0, 16'd7);
        cyc(0, 1, 0, 0, 3'd0, 16'd8);
        c_before = cnt_o[1];
        cyc(0, 0, 1, 1, 3'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_eq("flush.out_valid", 32'(ov[1]), 32'd0);
            check_eq("flush.ext_out", ext_o[1], 32'd0);
        end
        check_eq("flush.out_count", 32'(cnt_o[1]), 32'(c_before));

        // CNT_W=2 wrap after five deliveries
        cyc(1, 0, 0, 0, 3'd0, 16'h0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 3'd0, 16'(i + 10));
        idle(4);
        check_eq("wrap.out_count", 32'(cnt_o[2]), 32'd1);

        // Reset mid-stream
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 3'd1, 16'(16'hA000 + i));
        cyc(1, 1, 0, 0, 3'd1, 16'hBEEF);
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_mid.out_valid", 32'(ov[k]), 32'd0);
            check_eq("rst_mid.ext_out", ext_o[k], 32'd0);
            check_eq("rst_mid.out_count", 32'(cnt_o[k]), 32'd0);
            check_eq("rst_mid.err", 32'(er[k]), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1);
            for (int k = 0; k < 4; k++) check_eq("rst_mid.no_ghost", 32'(ov[k]), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) < 2),
                ($urandom_range(0, 19) == 0),
                3'($urandom_range(0, 7)),
                16'($urandom));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
